// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline hazard/forwarding controller.
package pipeline_pkg;

    // Upper bound on ADDR_W. The shadow struct lives in the package, so it
    // cannot take the module's width as a parameter. Narrower addresses are
    // zero-extended into this field.
    localparam int RD_MAX_W       = 8;

    localparam int DEF_DEPTH      = 3;
    localparam int DEF_LOAD_READY = 2;

    // A forwarding select of 0 means "read the register file".
    localparam int FWD_REGFILE    = 0;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_read;
        logic [RD_MAX_W-1:0] rd;
    } shadow_entry_t;

    localparam int ENTRY_W = $bits(shadow_entry_t);

endpackage

// File: rtl/hazard_shadow_pipe.sv
// DEPTH-entry shift register of destination tags for in-flight instructions.
// Entry 0 is EX. The back end never stalls, so the register shifts on every
// edge and the oldest entry retires.
module hazard_shadow_pipe
    import pipeline_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_ins_valid,
    input  shadow_entry_t            i_entry,
    output logic [DEPTH*ENTRY_W-1:0] o_entries
);

    logic [DEPTH*ENTRY_W-1:0] r_pipe;
    shadow_entry_t            w_in;

    // A rejected issue (stall, flush or idle ID) enters the pipe as an invalid bubble.
    always_comb begin
        w_in = i_ins_valid ? i_entry : shadow_entry_t'('0);
    end

    // Shift toward older entries and insert the new tag at entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= {r_pipe[(DEPTH-1)*ENTRY_W-1:0], w_in};
        end
    end

    assign o_entries = r_pipe;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller. It generates the load-use stall, the
// branch flush and the registered EX operand selects from a shadow pipeline
// of destination tags.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [SEL_W-1:0]  fwd_sel_rs,
    output logic [SEL_W-1:0]  fwd_sel_rt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [DEPTH*ENTRY_W-1:0] w_entries;
    shadow_entry_t            w_id_entry;
    logic                     w_issue;
    logic                     w_lu;
    logic                     w_flush;
    logic [SEL_W:0]           w_m_rs;
    logic [SEL_W:0]           w_m_rt;
    logic [SEL_W-1:0]         r_fwd_rs;
    logic [SEL_W-1:0]         r_fwd_rt;
    logic [CNT_W-1:0]         r_stall_cnt;
    logic [CNT_W-1:0]         r_flush_cnt;

    // Returns {load_use, select} for one source. The scan runs from oldest to
    // youngest, so the youngest matching producer overwrites older ones. A
    // match in the last entry selects the register file, which already sees
    // that write through.
    function automatic logic [SEL_W:0] match_src(
        input logic [RD_MAX_W-1:0]      src,
        input logic                     uses,
        input logic [DEPTH*ENTRY_W-1:0] ents
    );
        shadow_entry_t    e;
        logic             lu;
        logic [SEL_W-1:0] sel;
        lu  = 1'b0;
        sel = SEL_W'(FWD_REGFILE);
        for (int j = DEPTH - 1; j >= 0; j--) begin
            e = ents[j*ENTRY_W +: ENTRY_W];
            if (uses && e.valid && e.reg_write && (e.rd != '0) && (e.rd == src)) begin
                lu  = e.mem_read && ((j + 1) < LOAD_READY);
                sel = ((j + 1) <= (DEPTH - 1)) ? SEL_W'(j + 1) : SEL_W'(FWD_REGFILE);
            end
        end
        return {lu, sel};
    endfunction

    // Hazard detection. Reset masks every combinational output. A flush
    // overrides a stall so that the PC loads the branch target.
    always_comb begin
        w_m_rs  = match_src(RD_MAX_W'(id_rs), id_uses_rs, w_entries);
        w_m_rt  = match_src(RD_MAX_W'(id_rt), id_uses_rt, w_entries);
        w_flush = ex_branch_taken & ~reset;
        w_lu    = id_valid & (w_m_rs[SEL_W] | w_m_rt[SEL_W]) & ~reset;
        stall   = w_lu & ~w_flush;
        bubble  = w_lu | w_flush;
        flush   = w_flush;
        w_issue = id_valid & ~bubble;
        w_id_entry = '{valid:     1'b1,
                       reg_write: id_reg_write,
                       mem_read:  id_mem_read,
                       rd:        RD_MAX_W'(id_rd)};
    end

    hazard_shadow_pipe #(
        .DEPTH (DEPTH)
    ) u_shadow (
        .clk         (clk),
        .reset       (reset),
        .i_ins_valid (w_issue),
        .i_entry     (w_id_entry),
        .o_entries   (w_entries)
    );

    // Operand selects follow the instruction into EX. They are 0 for a bubble or an idle slot.
    always_ff @(posedge clk) begin
        if (reset || !w_issue) begin
            r_fwd_rs <= '0;
            r_fwd_rt <= '0;
        end else begin
            r_fwd_rs <= w_m_rs[SEL_W-1:0];
            r_fwd_rt <= w_m_rt[SEL_W-1:0];
        end
    end

    // Saturating debug counters for stall and flush cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign fwd_sel_rs = r_fwd_rs;
    assign fwd_sel_rt = r_fwd_rt;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share the stimulus:
// dut A uses the defaults, and dut B uses DEPTH=4, LOAD_READY=3, CNT_W=2.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_reg_write;
    logic       id_mem_read;
    logic [4:0] id_rd;
    logic       ex_branch_taken;

    logic        a_stall, a_bubble, a_flush;
    logic [1:0]  a_fwd_rs, a_fwd_rt;
    logic [15:0] a_stall_cnt, a_flush_cnt;

    logic        b_stall, b_bubble, b_flush;
    logic [1:0]  b_fwd_rs, b_fwd_rt;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut_a (
        .clk (clk), .reset (reset), .id_valid (id_valid),
        .id_rs (id_rs), .id_rt (id_rt), .id_uses_rs (id_uses_rs), .id_uses_rt (id_uses_rt),
        .id_reg_write (id_reg_write), .id_mem_read (id_mem_read), .id_rd (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .stall (a_stall), .bubble (a_bubble), .flush (a_flush),
        .fwd_sel_rs (a_fwd_rs), .fwd_sel_rt (a_fwd_rt),
        .stall_cnt (a_stall_cnt), .flush_cnt (a_flush_cnt)
    );

    pipeline_hazard_ctrl #(.DEPTH (4), .LOAD_READY (3), .CNT_W (2)) dut_b (
        .clk (clk), .reset (reset), .id_valid (id_valid),
        .id_rs (id_rs), .id_rt (id_rt), .id_uses_rs (id_uses_rs), .id_uses_rt (id_uses_rt),
        .id_reg_write (id_reg_write), .id_mem_read (id_mem_read), .id_rd (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .stall (b_stall), .bubble (b_bubble), .flush (b_flush),
        .fwd_sel_rs (b_fwd_rs), .fwd_sel_rt (b_fwd_rt),
        .stall_cnt (b_stall_cnt), .flush_cnt (b_flush_cnt)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the ID inputs, then let the combinational logic settle.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic rw,
                         input logic mr, input logic [4:0] rd);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_rd        = rd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        ex_branch_taken = 1'b0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ex_branch_taken = 1'b1;
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3);
        checks++;
        if (a_flush !== 1'b0 || a_stall !== 1'b0 || a_bubble !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: flush/stall/bubble=%b%b%b required 000", a_flush, a_stall, a_bubble);
        end
        tick();
        do_reset();
        checks++;
        if (a_fwd_rs !== 2'd0 || a_fwd_rt !== 2'd0 || a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_regs: fwd=%0d/%0d cnt=%0d/%0d required all 0", a_fwd_rs, a_fwd_rt, a_stall_cnt, a_flush_cnt);
        end
    endtask

    task automatic test_alu_forward();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);   // add r3,r1,r2
        tick();
        drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);   // sub r4,r3,r5
        checks++;
        if (a_stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_no_stall: stall=%b required 0", a_stall);
        end
        tick();
        idle();
        checks++;
        if (a_fwd_rs !== 2'd1 || a_fwd_rt !== 2'd0) begin
            errors++;
            $display("FAIL alu_fwd: fwd_rs=%0d fwd_rt=%0d required 1/0", a_fwd_rs, a_fwd_rt);
        end
        checks++;
        if (b_fwd_rs !== 2'd1) begin
            errors++;
            $display("FAIL alu_fwd_deep: fwd_rs=%0d required 1", b_fwd_rs);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);   // lw r3,0(r1)
        tick();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);   // add r4,r3,r3
        checks++;
        if (a_stall !== 1'b1 || a_bubble !== 1'b1 || a_flush !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall: stall/bubble/flush=%b%b%b required 110", a_stall, a_bubble, a_flush);
        end
        tick();
        #1;
        checks++;
        if (a_stall !== 1'b0 || a_bubble !== 1'b0) begin
            errors++;
            $display("FAIL lu_release: stall/bubble=%b%b required 00", a_stall, a_bubble);
        end
        tick();
        idle();
        checks++;
        if (a_fwd_rs !== 2'd2 || a_fwd_rt !== 2'd2 || a_stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_fwd: fwd=%0d/%0d cnt=%0d required 2/2 cnt 1", a_fwd_rs, a_fwd_rt, a_stall_cnt);
        end
    endtask

    // One load-use pair on dut B: two stall cycles, then the consumer issues.
    task automatic deep_pair();
        drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        tick();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        tick();
        tick();
        tick();
        idle();
    endtask

    task automatic test_deep_load_use();
        do_reset();
        drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        tick();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        checks++;
        if (b_stall !== 1'b1) begin
            errors++;
            $display("FAIL deep_stall1: stall=%b required 1", b_stall);
        end
        tick();
        #1;
        checks++;
        if (b_stall !== 1'b1) begin
            errors++;
            $display("FAIL deep_stall2: stall=%b required 1", b_stall);
        end
        tick();
        #1;
        checks++;
        if (b_stall !== 1'b0) begin
            errors++;
            $display("FAIL deep_release: stall=%b required 0", b_stall);
        end
        tick();
        idle();
        checks++;
        if (b_fwd_rs !== 2'd3 || b_fwd_rt !== 2'd3 || b_stall_cnt !== 2'd2) begin
            errors++;
            $display("FAIL deep_fwd: fwd=%0d/%0d cnt=%0d required 3/3 cnt 2", b_fwd_rs, b_fwd_rt, b_stall_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 3; i++) deep_pair();
        checks++;
        if (b_stall_cnt !== 2'd3) begin
            errors++;
            $display("FAIL cnt_saturate: stall_cnt=%0d required 3", b_stall_cnt);
        end
    endtask

    task automatic test_r0();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);   // lw r0,0(r1)
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);   // add r4,r0,r0
        checks++;
        if (a_stall !== 1'b0 || b_stall !== 1'b0) begin
            errors++;
            $display("FAIL r0_stall: stall a/b=%b%b required 00", a_stall, b_stall);
        end
        tick();
        idle();
        checks++;
        if (a_fwd_rs !== 2'd0 || a_fwd_rt !== 2'd0) begin
            errors++;
            $display("FAIL r0_fwd: fwd=%0d/%0d required 0/0", a_fwd_rs, a_fwd_rt);
        end
    endtask

    task automatic test_invalid_id();
        do_reset();
        drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        tick();
        drive(1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        checks++;
        if (a_stall !== 1'b0 || a_bubble !== 1'b0) begin
            errors++;
            $display("FAIL invalid_id: stall/bubble=%b%b required 00", a_stall, a_bubble);
        end
    endtask

    task automatic test_flush_over_stall();
        do_reset();
        drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        tick();
        ex_branch_taken = 1'b1;
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        checks++;
        if (a_flush !== 1'b1 || a_stall !== 1'b0 || a_bubble !== 1'b1) begin
            errors++;
            $display("FAIL flush_comb: flush/stall/bubble=%b%b%b required 101", a_flush, a_stall, a_bubble);
        end
        tick();
        ex_branch_taken = 1'b0;
        idle();
        checks++;
        if (a_flush_cnt !== 16'd1 || a_stall_cnt !== 16'd0 || a_fwd_rs !== 2'd0 || a_fwd_rt !== 2'd0) begin
            errors++;
            $display("FAIL flush_regs: flush_cnt=%0d stall_cnt=%0d fwd=%0d/%0d required 1 0 0/0",
                     a_flush_cnt, a_stall_cnt, a_fwd_rs, a_fwd_rt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        tick();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        checks++;
        if (a_stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: stall=%b required 1", a_stall);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (a_stall !== 1'b0 || a_bubble !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_comb: stall/bubble=%b%b required 00", a_stall, a_bubble);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (a_stall !== 1'b0 || b_stall !== 1'b0 || a_fwd_rs !== 2'd0 || a_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_after: stall a/b=%b%b fwd=%0d cnt=%0d required 00 0 0",
                     a_stall, b_stall, a_fwd_rs, a_stall_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_deep_load_use();
        test_saturation();
        test_r0();
        test_invalid_id();
        test_flush_over_stall();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
